// File: rtl/fft_pkg.sv
// fft_pkg: shared sizes, buffer state encoding and bit-reverse helper
package fft_pkg;
  localparam int WORDSIZE   = 16;
  localparam int NUMSAMPLES = 32;
  localparam int LOG2N      = 5;
  typedef enum logic [1:0] {IDLE = 2'b00, COLLECT = 2'b01, FULL = 2'b10} state_t;
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx);
    for (int i = 0; i < LOG2N; i++) bitrev[i] = idx[LOG2N-1-i];
  endfunction
endpackage

// File: rtl/bitrev_ram.sv
// bitrev_ram: 4-write-port sample RAM split into even/odd banks with registered pair read
module bitrev_ram
  import fft_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [3:0][LOG2N-1:0]         wa,
  input  logic [3:0][WORDSIZE-1:0]      wd,
  input  logic                          re,
  input  logic [LOG2N-2:0]              ra,
  output logic [WORDSIZE-1:0]           rd0,
  output logic [WORDSIZE-1:0]           rd1
);
  logic [WORDSIZE-1:0] even_mem [NUMSAMPLES/2];
  logic [WORDSIZE-1:0] odd_mem  [NUMSAMPLES/2];
  always_ff @(posedge clk) begin
    if (we)
      for (int k = 0; k < 4; k++)
        if (wa[k][0]) odd_mem[wa[k][LOG2N-1:1]] <= wd[k];
        else even_mem[wa[k][LOG2N-1:1]] <= wd[k];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd0 <= '0;
      rd1 <= '0;
    end else if (re) begin
      rd0 <= even_mem[ra];
      rd1 <= odd_mem[ra];
    end
  end
endmodule

// File: rtl/bitrev_buffer.sv
// bitrev_buffer: collects a frame 4 words per cycle in bit-reversed order, then serves even/odd pairs
module bitrev_buffer
  import fft_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WORDSIZE-1:0]  in_data0,
  input  logic [WORDSIZE-1:0]  in_data1,
  input  logic [WORDSIZE-1:0]  in_data2,
  input  logic [WORDSIZE-1:0]  in_data3,
  input  logic                 in_last,
  output logic                 in_ready,
  input  logic                 rd_en,
  input  logic [LOG2N-2:0]     rd_addr,
  output logic [WORDSIZE-1:0]  rd_data0,
  output logic [WORDSIZE-1:0]  rd_data1,
  output logic                 rd_valid,
  output logic                 frame_ready,
  input  logic                 frame_release,
  output logic                 error
);
  state_t             state, state_n;
  logic [LOG2N:0]     wr_cnt, cnt_n;
  logic               err_n;
  logic [3:0][LOG2N-1:0] wa;
  logic               rd_go;
  assign in_ready    = state != FULL;
  assign frame_ready = state == FULL;
  assign rd_go       = rd_en && state == FULL;
  for (genvar k = 0; k < 4; k++) begin : g_wa
    assign wa[k] = bitrev(wr_cnt[LOG2N-1:0] + LOG2N'(k));
  end
  always_comb begin
    state_n = state;
    cnt_n   = wr_cnt;
    err_n   = error;
    case (state)
      IDLE: if (in_valid) begin
        state_n = COLLECT;
        cnt_n   = (LOG2N+1)'(4);
      end
      COLLECT: if (in_valid) begin
        cnt_n = wr_cnt + (LOG2N+1)'(4);
        if (cnt_n == (LOG2N+1)'(NUMSAMPLES)) state_n = FULL;
      end else if (in_last) begin
        err_n   = 1'b1;
        state_n = FULL;
      end
      FULL: begin
        // writes are dropped while full, even in the release cycle
        if (in_valid) err_n = 1'b1;
        if (frame_release) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_cnt   <= '0;
      error    <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_n;
      wr_cnt   <= cnt_n;
      error    <= err_n;
      rd_valid <= rd_go;
    end
  end
  bitrev_ram u_ram (
    .clk (clk),
    .rst (rst),
    .we  (in_valid && state != FULL && !rst),
    .wa  (wa),
    .wd  ({in_data3, in_data2, in_data1, in_data0}),
    .re  (rd_go),
    .ra  (rd_addr),
    .rd0 (rd_data0),
    .rd1 (rd_data1)
  );
endmodule

// File: tb/tb_bitrev_buffer.sv
// tb_bitrev_buffer: directed-vector bench for bitrev_buffer
module tb_bitrev_buffer;
  logic        clk = 0;
  logic        rst, in_valid, in_last, in_ready, rd_en, rd_valid, frame_ready, frame_release, error;
  logic [15:0] in_data0, in_data1, in_data2, in_data3, rd_data0, rd_data1;
  logic [3:0]  rd_addr;
  int          tests = 0, fails = 0;

  bitrev_buffer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
    .in_last(in_last), .in_ready(in_ready), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data0(rd_data0), .rd_data1(rd_data1), .rd_valid(rd_valid),
    .frame_ready(frame_ready), .frame_release(frame_release), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int base, input int idx);
    in_valid = 1;
    in_data0 = 16'(base + idx);
    in_data1 = 16'(base + idx + 1);
    in_data2 = 16'(base + idx + 2);
    in_data3 = 16'(base + idx + 3);
    tick();
    in_valid = 0;
  endtask

  task automatic beats(input int base, input int n);
    for (int b = 0; b < n; b++) beat(base, 4 * b);
  endtask

  task automatic rd_pair(input string tag, input int addr, input int e0, input int e1);
    rd_en   = 1;
    rd_addr = 4'(addr);
    tick();
    rd_en   = 0;
    chk({tag, "_valid"}, 32'(rd_valid), 1);
    chk({tag, "_d0"}, 32'(rd_data0), 32'(e0));
    chk({tag, "_d1"}, 32'(rd_data1), 32'(e1));
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic do_release();
    frame_release = 1;
    tick();
    frame_release = 0;
  endtask

  initial begin
    {rst, in_valid, in_last, rd_en, frame_release} = '0;
    {in_data0, in_data1, in_data2, in_data3} = '0;
    rd_addr = '0;
    // test 1: reset state and a full frame of 0..31
    do_reset();
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_frame_ready", 32'(frame_ready), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data0", 32'(rd_data0), 0);
    beats(0, 7);
    chk("t1_not_full_7", 32'(frame_ready), 0);
    beat(0, 28);
    chk("t1_frame_ready", 32'(frame_ready), 1);
    chk("t1_in_ready", 32'(in_ready), 0);
    chk("t1_error", 32'(error), 0);
    // test 2: pair reads
    rd_pair("t2_a0", 0, 0, 16);
    rd_pair("t2_a1", 1, 8, 24);
    rd_pair("t2_a15", 15, 15, 31);
    tick();
    chk("t2_valid_drop", 32'(rd_valid), 0);
    chk("t2_hold_d0", 32'(rd_data0), 15);
    chk("t2_hold_d1", 32'(rd_data1), 31);
    // test 3: overflow, release, new frame
    beat(500, 0);
    chk("t3_overflow_err", 32'(error), 1);
    rd_pair("t3_reread", 0, 0, 16);
    do_release();
    chk("t3_rel_frame_ready", 32'(frame_ready), 0);
    chk("t3_rel_in_ready", 32'(in_ready), 1);
    beats(100, 8);
    chk("t3_full2", 32'(frame_ready), 1);
    rd_pair("t3_a0", 0, 100, 116);
    chk("t3_err_sticky", 32'(error), 1);
    // test 4: short frame over stale frame 100+
    do_reset();
    chk("t4_rst_err", 32'(error), 0);
    beats(300, 5);
    chk("t4_collecting", 32'(frame_ready), 0);
    in_last = 1;
    tick();
    chk("t4_short_err", 32'(error), 1);
    chk("t4_short_full", 32'(frame_ready), 1);
    rd_pair("t4_a0", 0, 300, 316);
    rd_pair("t4_a1", 1, 308, 124);
    in_last = 0;
    // test 5: reset mid-frame, then full frame 200+
    do_reset();
    beats(400, 3);
    do_reset();
    chk("t5_frame_ready", 32'(frame_ready), 0);
    chk("t5_in_ready", 32'(in_ready), 1);
    beats(200, 8);
    chk("t5_full", 32'(frame_ready), 1);
    rd_pair("t5_a1", 1, 208, 224);
    chk("t5_error", 32'(error), 0);
    // test 6: reads outside FULL ignored; read in release cycle served
    do_release();
    rd_en = 1;
    rd_addr = 4'd3;
    tick();
    chk("t6_idle_rd", 32'(rd_valid), 0);
    rd_en = 0;
    beat(0, 0);
    rd_en = 1;
    tick();
    chk("t6_collect_rd", 32'(rd_valid), 0);
    rd_en = 0;
    for (int b = 1; b < 8; b++) beat(0, 4 * b);
    chk("t6_full", 32'(frame_ready), 1);
    rd_en = 1;
    rd_addr = 4'd15;
    frame_release = 1;
    tick();
    rd_en = 0;
    frame_release = 0;
    chk("t6_rel_rd_valid", 32'(rd_valid), 1);
    chk("t6_rel_d0", 32'(rd_data0), 15);
    chk("t6_rel_d1", 32'(rd_data1), 31);
    chk("t6_rel_idle", 32'(frame_ready), 0);
    tick();
    chk("t6_valid_once", 32'(rd_valid), 0);
    chk("t6_in_ready", 32'(in_ready), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
